// File: rtl/wr_rr_arbiter_pkg.sv
// wr_rr_arbiter_pkg
//   Shared constants and types for the shared-memory switch write-path
//   arbiter: port count, datapath width, default select width and the
//   per-output grant FSM state encoding.
package wr_rr_arbiter_pkg;

  localparam int unsigned PORT_NUB_TOTAL = 8;
  localparam int unsigned DATA_WIDTH     = 64;
  localparam int unsigned SEL_W_DFLT     = $clog2(PORT_NUB_TOTAL);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_e;

endpackage

// File: rtl/wr_rr_arbiter_rr_pick.sv
// wr_rr_arbiter_rr_pick
//   Combinational round-robin picker: returns the first set bit of req at or
//   after ptr, wrapping modulo N.
// Ports:
//   req  in  N          request vector
//   ptr  in  WIDTH_SEL  search start index
//   vld  out 1          any request present
//   idx  out WIDTH_SEL  picked index (0 when vld is low)
module wr_rr_arbiter_rr_pick #(
  parameter int unsigned N         = 8,
  parameter int unsigned WIDTH_SEL = $clog2(N)
) (
  input  logic [N-1:0]         req,
  input  logic [WIDTH_SEL-1:0] ptr,
  output logic                 vld,
  output logic [WIDTH_SEL-1:0] idx
);

  logic [2*N-1:0] req_dbl;
  logic [2*N-1:0] mask;
  logic [2*N-1:0] masked;

  // The upper copy is never masked, so a wrapped requester is always found
  // there once everything at or above ptr in the lower copy is empty.
  always_comb begin
    req_dbl = {req, req};
    mask    = {(2*N){1'b1}} << ptr;
    masked  = req_dbl & mask;
    vld     = |req;
    idx     = '0;
    for (int k = int'(2*N) - 1; k >= 0; k--) begin
      if (masked[k]) idx = WIDTH_SEL'(k % int'(N));
    end
  end

endmodule

// File: rtl/wr_rr_arbiter.sv
// wr_rr_arbiter
//   Per-output-queue round-robin arbiter for the switch write path. Each
//   output locks onto one input until that input's packet ends (or the
//   owner goes idle for TIMEOUT cycles), driving the queue write strobe,
//   the input-mux select and the per-input ready.
// Ports:
//   clk        in  1            clock
//   rst_n      in  1            async active-low reset
//   port_req   in  N*N          bit j*N+i: input j has a beat for output i
//   eop_in     in  N            per input: current beat ends the packet
//   full_in    in  N            per output queue full
//   wr_en_out  out N            per output queue write strobe
//   mux_sel    out N*WIDTH_SEL  field i: input granted to output i
//   in_ready   out N            per input: beat consumed this cycle
//   busy_out   out N            per output: grant locked
//
// Per-output FSM:
//   state   | meaning
//   IDLE    | no owner; pick a requester round-robin from ptr
//   LOCK    | owner fixed; write owner beats until EOP or idle timeout
module wr_rr_arbiter
  import wr_rr_arbiter_pkg::*;
#(
  parameter int unsigned N         = PORT_NUB_TOTAL,
  parameter int unsigned WIDTH_SEL = $clog2(N),
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N*N-1:0]         port_req,
  input  logic [N-1:0]           eop_in,
  input  logic [N-1:0]           full_in,
  output logic [N-1:0]           wr_en_out,
  output logic [N*WIDTH_SEL-1:0] mux_sel,
  output logic [N-1:0]           in_ready,
  output logic [N-1:0]           busy_out
);

  localparam int unsigned TMO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = (TIMEOUT > 0) ? TMO_W'(TIMEOUT - 1) : '0;

  for (genvar gi = 0; gi < N; gi++) begin : g_out
    arb_state_e           state_q, state_d;
    logic [WIDTH_SEL-1:0] owner_q, owner_d;
    logic [WIDTH_SEL-1:0] ptr_q, ptr_d;
    logic [TMO_W-1:0]     tmo_q, tmo_d;
    logic [N-1:0]         req_col;
    logic                 pick_vld;
    logic [WIDTH_SEL-1:0] pick_idx;
    logic [WIDTH_SEL-1:0] owner_nxt;
    logic                 own_req;
    logic                 own_eop;
    logic                 wr;

    always_comb begin
      req_col = '0;
      for (int j = 0; j < int'(N); j++) req_col[j] = port_req[j*N + gi];
    end

    wr_rr_arbiter_rr_pick #(
      .N         (N),
      .WIDTH_SEL (WIDTH_SEL)
    ) u_pick (
      .req (req_col),
      .ptr (ptr_q),
      .vld (pick_vld),
      .idx (pick_idx)
    );

    assign own_req   = req_col[owner_q];
    assign own_eop   = eop_in[owner_q];
    assign owner_nxt = (owner_q == WIDTH_SEL'(N - 1)) ? '0 : owner_q + 1'b1;
    assign wr        = (state_q == ST_LOCK) && own_req && !full_in[gi];

    always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      tmo_d   = tmo_q;
      case (state_q)
        ST_IDLE: begin
          if (pick_vld) begin
            state_d = ST_LOCK;
            owner_d = pick_idx;
            tmo_d   = '0;
          end
        end
        ST_LOCK: begin
          if (wr && own_eop) begin
            state_d = ST_IDLE;
            ptr_d   = owner_nxt;
            tmo_d   = '0;
          end else if (own_req) begin
            tmo_d = '0;
          end else if (!full_in[gi] && TIMEOUT != 0) begin
            // Backpressure freezes the counter; only a genuinely idle owner
            // advances it. The packet is abandoned on the last idle cycle.
            if (tmo_q == TMO_LAST) begin
              state_d = ST_IDLE;
              ptr_d   = owner_nxt;
              tmo_d   = '0;
            end else begin
              tmo_d = tmo_q + 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= ST_IDLE;
        owner_q <= '0;
        ptr_q   <= '0;
        tmo_q   <= '0;
      end else begin
        state_q <= state_d;
        owner_q <= owner_d;
        ptr_q   <= ptr_d;
        tmo_q   <= tmo_d;
      end
    end

    assign wr_en_out[gi]                         = wr;
    assign busy_out[gi]                          = (state_q == ST_LOCK);
    assign mux_sel[gi*WIDTH_SEL +: WIDTH_SEL]    = owner_q;
  end

  // At most one output can own a given input, so at most one term per bit.
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < int'(N); i++) begin
      for (int j = 0; j < int'(N); j++) begin
        if (wr_en_out[i] && (mux_sel[i*WIDTH_SEL +: WIDTH_SEL] == WIDTH_SEL'(j)))
          in_ready[j] = 1'b1;
      end
    end
  end

  for (genvar gj = 0; gj < N; gj++) begin : g_chk
    a_one_output: assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0(port_req[gj*N +: N]));
  end

endmodule

// File: tb/tb_wr_rr_arbiter.sv
module tb_wr_rr_arbiter;

  localparam int N  = 4;
  localparam int WS = 2;

  logic          clk;
  logic          rst_n;
  logic [N*N-1:0] port_req;
  logic [N-1:0]  eop_in;
  logic [N-1:0]  full_in;
  logic [N-1:0]  wr_en_out;
  logic [N*WS-1:0] mux_sel;
  logic [N-1:0]  in_ready;
  logic [N-1:0]  busy_out;

  int n_chk = 0;
  int n_err = 0;

  wr_rr_arbiter #(.N(N), .WIDTH_SEL(WS), .TIMEOUT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .port_req  (port_req),
    .eop_in    (eop_in),
    .full_in   (full_in),
    .wr_en_out (wr_en_out),
    .mux_sel   (mux_sel),
    .in_ready  (in_ready),
    .busy_out  (busy_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [15:0] req;
    logic [3:0]  eop;
    logic [3:0]  full;
    logic [3:0]  wr;
    logic [3:0]  rdy;
    logic [3:0]  busy;
    logic [7:0]  mux;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [15:0] rq(input int j, input int i);
    logic [15:0] one;
    one = 16'd1;
    return one << (j*N + i);
  endfunction

  task automatic add(input logic [15:0] req, input logic [3:0] eop, input logic [3:0] full,
                     input logic [3:0] wr, input logic [3:0] rdy, input logic [3:0] busy,
                     input logic [7:0] mux);
    vec_t v;
    v.req = req; v.eop = eop; v.full = full;
    v.wr = wr; v.rdy = rdy; v.busy = busy; v.mux = mux;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  logic [15:0] all0;

  initial begin
    rst_n    = 1'b0;
    port_req = '0;
    eop_in   = '0;
    full_in  = '0;
    all0     = rq(0,0) | rq(1,0) | rq(2,0) | rq(3,0);

    // Test 1: 3-beat packet input 2 -> output 1, then ptr[1]=3 evidence.
    add(rq(2,1),         4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'h00);
    add(rq(2,1),         4'b0000, 4'b0000, 4'b0010, 4'b0100, 4'b0010, 8'h08);
    add(rq(2,1),         4'b0000, 4'b0000, 4'b0010, 4'b0100, 4'b0010, 8'h08);
    add(rq(2,1),         4'b0100, 4'b0000, 4'b0010, 4'b0100, 4'b0010, 8'h08);
    add(16'h0,           4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'h08);
    add(rq(0,1)|rq(3,1), 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'h08);
    add(rq(0,1)|rq(3,1), 4'b1000, 4'b0000, 4'b0010, 4'b1000, 4'b0010, 8'h0C);
    add(rq(0,1),         4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'h0C);
    add(rq(0,1),         4'b0001, 4'b0000, 4'b0010, 4'b0001, 4'b0010, 8'h00);
    add(16'h0,           4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'h00);
    // Test 2: all inputs -> output 0, single beats, strict rotation.
    add(all0, 4'hF, 4'h0, 4'b0000, 4'b0000, 4'b0000, 8'h00);
    add(all0, 4'hF, 4'h0, 4'b0001, 4'b0001, 4'b0001, 8'h00);
    add(all0, 4'hF, 4'h0, 4'b0000, 4'b0000, 4'b0000, 8'h00);
    add(all0, 4'hF, 4'h0, 4'b0001, 4'b0010, 4'b0001, 8'h01);
    add(all0, 4'hF, 4'h0, 4'b0000, 4'b0000, 4'b0000, 8'h01);
    add(all0, 4'hF, 4'h0, 4'b0001, 4'b0100, 4'b0001, 8'h02);
    add(all0, 4'hF, 4'h0, 4'b0000, 4'b0000, 4'b0000, 8'h02);
    add(all0, 4'hF, 4'h0, 4'b0001, 4'b1000, 4'b0001, 8'h03);
    add(all0, 4'hF, 4'h0, 4'b0000, 4'b0000, 4'b0000, 8'h03);
    add(all0, 4'hF, 4'h0, 4'b0001, 4'b0001, 4'b0001, 8'h00);
    add(16'h0, 4'h0, 4'h0, 4'b0000, 4'b0000, 4'b0000, 8'h00);
    // Test 5: input 0 -> out 0 and input 1 -> out 1 concurrently.
    add(rq(0,0)|rq(1,1), 4'b0000, 4'h0, 4'b0000, 4'b0000, 4'b0000, 8'h00);
    add(rq(0,0)|rq(1,1), 4'b0000, 4'h0, 4'b0011, 4'b0011, 4'b0011, 8'h04);
    add(rq(0,0)|rq(1,1), 4'b0011, 4'h0, 4'b0011, 4'b0011, 4'b0011, 8'h04);
    add(16'h0,           4'b0000, 4'h0, 4'b0000, 4'b0000, 4'b0000, 8'h04);

    @(negedge clk); #1;
    check("rst wr", wr_en_out, 0);
    check("rst rdy", in_ready, 0);
    check("rst busy", busy_out, 0);
    check("rst mux", mux_sel, 0);
    @(negedge clk); rst_n = 1'b1;

    foreach (tbl[k]) begin
      @(negedge clk);
      port_req = tbl[k].req; eop_in = tbl[k].eop; full_in = tbl[k].full;
      #1;
      check($sformatf("row%0d wr", k),   wr_en_out, tbl[k].wr);
      check($sformatf("row%0d rdy", k),  in_ready,  tbl[k].rdy);
      check($sformatf("row%0d busy", k), busy_out,  tbl[k].busy);
      check($sformatf("row%0d mux", k),  mux_sel,   tbl[k].mux);
    end

    // Test 3: input 1 locked on output 0, queue full for 5 cycles.
    @(negedge clk); port_req = rq(1,0); eop_in = '0; full_in = '0; #1;
    check("t3 idle busy", busy_out[0], 0);
    @(negedge clk); #1;
    check("t3 wr", wr_en_out[0], 1);
    check("t3 mux", mux_sel[1:0], 1);
    check("t3 rdy", in_ready, 4'b0010);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); full_in = 4'b0001; #1;
      check($sformatf("t3 full%0d wr", c), wr_en_out[0], 0);
      check($sformatf("t3 full%0d busy", c), busy_out[0], 1);
      check($sformatf("t3 full%0d mux", c), mux_sel[1:0], 1);
      check($sformatf("t3 full%0d rdy", c), in_ready, 0);
    end
    @(negedge clk); full_in = '0; #1;
    check("t3 resume wr", wr_en_out[0], 1);
    check("t3 resume rdy", in_ready, 4'b0010);
    @(negedge clk); eop_in = 4'b0010; #1;
    check("t3 eop wr", wr_en_out[0], 1);
    @(negedge clk); port_req = '0; eop_in = '0; #1;
    check("t3 end busy", busy_out[0], 0);

    // Test 4: owner 3 on output 2 goes idle; timeout, then input 1 wins.
    @(negedge clk); port_req = rq(3,2); #1;
    check("t4 idle busy", busy_out[2], 0);
    @(negedge clk); port_req = rq(3,2) | rq(1,2); #1;
    check("t4 wr", wr_en_out[2], 1);
    check("t4 mux", mux_sel[5:4], 3);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); port_req = rq(1,2); #1;
      check($sformatf("t4 idle%0d busy", c), busy_out[2], 1);
      check($sformatf("t4 idle%0d wr", c), wr_en_out[2], 0);
    end
    @(negedge clk); #1;
    check("t4 timeout busy", busy_out[2], 0);
    @(negedge clk); eop_in = 4'b0010; #1;
    check("t4 regrant busy", busy_out[2], 1);
    check("t4 regrant mux", mux_sel[5:4], 1);
    check("t4 regrant rdy", in_ready, 4'b0010);
    @(negedge clk); port_req = '0; eop_in = '0; #1;
    check("t4 end busy", busy_out[2], 0);

    // Test 6: reset mid-packet on output 3.
    @(negedge clk); port_req = rq(2,3); #1;
    @(negedge clk); #1;
    check("t6 busy", busy_out[3], 1);
    check("t6 mux", mux_sel[7:6], 2);
    check("t6 wr", wr_en_out[3], 1);
    #2; rst_n = 1'b0; #1;
    check("t6 rst wr", wr_en_out, 0);
    check("t6 rst rdy", in_ready, 0);
    check("t6 rst busy", busy_out, 0);
    check("t6 rst mux", mux_sel, 0);
    @(negedge clk);
    @(negedge clk); rst_n = 1'b1; port_req = all0; eop_in = 4'hF; #1;
    check("t6 post idle", busy_out, 0);
    @(negedge clk); #1;
    check("t6 post mux", mux_sel[1:0], 0);
    check("t6 post rdy", in_ready, 4'b0001);
    check("t6 post wr", wr_en_out, 4'b0001);
    @(negedge clk); port_req = '0; eop_in = '0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/wr_rr_arbiter.md
Name: wr_rr_arbiter

Overview:
- Per-output-queue arbiter for the shared-memory switch write path.
- For each output queue, picks one requesting input port round-robin and locks that grant until the input's packet ends.
- Drives the queue write enables and the per-output input-mux selects, and returns per-input ready.
- Replaces fixed-priority selection so no input port can starve another on a congested output.

Parameters:
- N, 8, number of switch ports (equals PORT_NUB_TOTAL).
- WIDTH_SEL, $clog2(N), width of one mux select field.
- TIMEOUT, 255, max consecutive idle cycles a locked grant may hold with owner request low; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- port_req  in  N*N  bit j*N+i = input j has a beat for output i; each input asserts at most one output at a time.
- eop_in  in  N  per input: current beat is the last of its packet.
- full_in  in  N  per output queue full.
- wr_en_out  out  N  per output queue write strobe.
- mux_sel  out  N*WIDTH_SEL  field i = input index granted to output i.
- in_ready  out  N  per input: its beat is consumed this cycle.
- busy_out  out  N  per output: grant locked.

Behaviour:
- Reset (async): all outputs 0; every output FSM in IDLE; RR pointers 0; timeout counters 0.
- Per output i, independent FSM with states IDLE and LOCK:
  - IDLE: if any request for output i, pick the first requester at or after ptr[i], wrapping modulo N. Register owner[i] = pick and enter LOCK at the next edge.
  - IDLE outputs: no write in IDLE; wr_en_out[i] = 0.
  - Latency: request seen in cycle t; first write possible in cycle t+1.
  - LOCK: wr_en_out[i] = port_req[owner*N+i] & !full_in[i]. This is combinational from registered state; no other input can win while locked.
  - LOCK -> IDLE when wr_en_out[i] & eop_in[owner]. Then ptr[i] = owner+1, wrapping N-1 to 0.
  - Owner request low without EOP: stay in LOCK, no write, timeout counter increments. The counter clears on any owner request.
  - When the counter reaches TIMEOUT: go to IDLE and set ptr[i] = owner+1 (abandon the packet).
  - full_in[i] high while LOCK: hold, no write, no timeout increment (backpressure is not idleness).
- mux_sel[i] = owner[i]: updated only on the IDLE->LOCK edge and held in IDLE, so the datapath stays stable.
- busy_out[i] = (state == LOCK).
- in_ready[j] = OR over i of (wr_en_out[i] & owner[i]==j). The precondition guarantees at most one term is set.
- Single-beat packet (EOP on the first beat): one write, then IDLE. The next grant can be registered in that same IDLE cycle, giving a minimum 2-cycle spacing per output.
- Simultaneous requests from all N inputs: grants rotate strictly in RR order.
- Reset asserted mid-packet: immediate return to IDLE; the partial packet is dropped by the queue logic, not here.
- Violation of the one-output-per-input precondition: simulation assertion fires; RTL behaviour undefined.

Decomposition:
- Shared header (generate_parameter.vh) holds:
  - PORT_NUB_TOTAL and DATA_WIDTH;
  - a WIDTH_SEL macro = $clog2(PORT_NUB_TOTAL);
  - the FSM state encodings IDLE=0 and LOCK=1.
- Sub-module rr_pick:
  - inputs N-bit req and WIDTH_SEL-bit ptr; outputs a valid flag and a WIDTH_SEL index;
  - purely combinational, using a double-width masked priority search;
  - instantiated once per output in a generate loop.
- The FSM, pointer, timeout counter and owner register are per output, inside the same generate loop.

Test Plan (N=4, TIMEOUT=4):
1. Reset, then input 2 requests output 1 for a 3-beat packet (EOP on beat 3) with full=0:
   - busy_out[1] rises at cycle t+1; mux_sel field1=2;
   - wr_en_out[1] and in_ready[2] high for 3 cycles, then IDLE;
   - ptr[1]=3.
2. Inputs 0, 1, 2, 3 all request output 0 with single-beat packets, held continuously:
   - grant order 0, 1, 2, 3, 0, one write every 2 cycles;
   - in_ready follows that owner sequence.
3. Locked grant 1->0, full_in[0]=1 for 5 cycles mid-packet:
   - wr_en_out[0]=0 and owner unchanged during full;
   - no timeout;
   - writes resume the cycle full drops.
4. Owner 3 on output 2 drops request without EOP:
   - after 4 idle cycles busy_out[2] falls;
   - pending input 1 is granted next, with ptr starting at 0.
5. Inputs 0->out0 and 1->out1 concurrently:
   - both lock in the same cycle;
   - mux_sel=(0,1), in_ready=0b0011 while both write.
6. rst_n pulsed low during LOCK:
   - wr_en_out, in_ready, busy_out and mux_sel go 0 asynchronously;
   - after release, arbitration restarts from ptr=0.
